inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Fetch sequencer for the 4-read-port instruction SRAM.
- Each cycle it can issue one aligned 4-instruction fetch group: one word per SRAM port, lanes enabled per alignment mask.
- It captures the registered SRAM read data one cycle later and buffers groups in a small FIFO toward decode with a valid/ready handshake.
- It handles redirects (branch/exception) by flushing buffered and in-flight groups.

Parameters:
- ADDR_WIDTH, 32, instruction address width.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch-group buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- fetch_en  in  1  permit new fetch issue.
- redirect_valid  in  1  redirect request this cycle.
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored.
- sram_enN (N=0..3)  out  1  read enable for SRAM port N.
- sram_raddrN (N=0..3)  out  ADDR_WIDTH  read byte address for port N.
- sram_rdataN (N=0..3)  in  DATA_WIDTH  registered read data for port N, valid one cycle after enable.
- out_valid  out  1  FIFO head holds a group.
- out_ready  in  1  decode accepts the head.
- out_pc  out  ADDR_WIDTH  address of the first valid instruction in the head group.
- out_instN (N=0..3)  out  DATA_WIDTH  head group instructions.
- out_mask  out  4  per-lane valid bits.

Behaviour:
- Reset (rst=1 at posedge):
  - pc_q <= RESET_PC; in-flight flag cleared; FIFO emptied.
  - out_valid=0; out_pc, out_instN and out_mask read 0 while the FIFO is empty.
  - sram_enN=0 during the reset cycle.
  - Reset mid-operation discards any in-flight response.
- Group addressing:
  - base = {pc_q[31:4], 4'b0}; sram_raddrN = base + 4*N.
  - mask = 4'b1111 << pc_q[3:2]; sram_enN = issue & mask[N].
- Issue condition: fetch_en & !redirect_valid & !rst & (count + inflight - (out_valid & out_ready) < FIFO_DEPTH).
  - The combinational out_ready term is intended; it allows 1 group/cycle sustained at FIFO_DEPTH=2.
- On issue:
  - pc_q <= base + 16, with 32-bit wrap: 0xFFFF_FFF0 -> 0x0000_0000.
  - inflight <= 1; the in-flight {pc_q, mask} is captured.
- Latency:
  - Issue in cycle t; sram_rdataN valid in t+1; group written to FIFO at end of t+1; out_valid visible at t+2.
- Capture: lanes with mask=0 are written as instruction 0. SRAM outputs for non-enabled lanes hold stale data and must not leak.
- Pop: out_valid & out_ready at posedge removes the head. Push and pop in the same cycle are both allowed; count is unchanged.
- Credit rule guarantees no push when the FIFO is full; overflow is an assertion failure.
- Redirect (redirect_valid=1 in cycle t):
  - pc_q <= {redirect_pc[31:2], 2'b00}; FIFO flushed; in-flight response arriving in t+1 discarded.
  - No issue in t; first new issue in t+1.
  - Redirect has priority over a simultaneous pop; the pop is ignored.
  - Back-to-back redirects: the last one wins.
- fetch_en=0: no new issue. The in-flight group still completes and the FIFO drains normally. pc_q holds.
- FSM (2 states):
  - IDLE: after reset, or while fetch_en=0 with nothing in flight.
  - RUN: otherwise.
  - Transitions are determined purely by fetch_en and the in-flight flag.

Decomposition:
- Package fetch_pkg holds:
  - FETCH_WIDTH=4, GROUP_BYTES=16.
  - typedef fetch_group_t {pc, inst[FETCH_WIDTH], mask}.
  - Function group_mask(pc).
- Sub-module fetch_group_fifo: synchronous FIFO of fetch_group_t.
  - Parameter FIFO_DEPTH; inputs push, pop, flush; outputs count, head, empty, full.
  - flush has priority over push/pop.

Test Plan:
1. Reset release, fetch_en=1, out_ready=1:
   - Cycle 0: sram_en=1111, raddr 0x8000_0000/04/08/0C.
   - Cycle 2: out_valid, out_pc=0x8000_0000, mask=1111.
   - Thereafter one group per cycle, pc advancing by 16.
2. Redirect to 0x8000_002A:
   - Next issue has raddr base 0x8000_0020; en only on lanes 2 and 3.
   - out_mask=1100, out_pc=0x8000_0028, out_inst0=out_inst1=0.
   - Following group pc 0x8000_0030.
3. out_ready=0 for 10 cycles:
   - After 2 groups are buffered, sram_en stays 0.
   - On release, groups emerge in order with no loss or duplication, then 1 group/cycle resumes.
4. Redirect while FIFO full and a group in flight:
   - out_valid=0 in the next cycle; no stale group ever appears.
   - First out_pc after the redirect equals the target.
5. Redirect to 0xFFFF_FFF4:
   - mask=1110; next group raddr0=0x0000_0000 (wrap).
6. fetch_en=0 mid-stream, then rst=1 with a group in flight:
   - FIFO drains; no issue; after reset out_valid=0.
   - First issue is back at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// fetch_pkg: shared fetch-group type, sizing constants and lane-mask helper
// for the 4-wide instruction fetch controller.
package fetch_pkg;

  localparam int FETCH_WIDTH    = 4;
  localparam int GROUP_BYTES    = 16;
  localparam int PKG_ADDR_WIDTH = 32;
  localparam int PKG_DATA_WIDTH = 32;

  typedef struct packed {
    logic [PKG_ADDR_WIDTH-1:0]                   pc;
    logic [FETCH_WIDTH-1:0][PKG_DATA_WIDTH-1:0]  inst;
    logic [FETCH_WIDTH-1:0]                      mask;
  } fetch_group_t;

  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  // Lanes at or above the word offset of pc within its 16-byte group are valid.
  function automatic logic [FETCH_WIDTH-1:0] group_mask(input logic [1:0] pc_word);
    return FETCH_WIDTH'(4'b1111 << pc_word);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_group_fifo.sv
`default_nettype none
// fetch_group_fifo: synchronous FIFO of fetch groups; flush overrides
// push and pop in the same cycle.
module fetch_group_fifo
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  fetch_group_t                din,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output fetch_group_t                head,
  output logic                        empty,
  output logic                        full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  fetch_group_t   mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~full;
  assign head    = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// inst_fetch_ctrl: issues aligned 4-word fetch groups to a 4-port SRAM,
// captures the responses and queues them toward decode; redirects flush.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                     ADDR_WIDTH = 32,
  parameter int                     DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'h8000_0000,
  parameter int                     FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  sram_en0,
  output logic                  sram_en1,
  output logic                  sram_en2,
  output logic                  sram_en3,
  output logic [ADDR_WIDTH-1:0] sram_raddr0,
  output logic [ADDR_WIDTH-1:0] sram_raddr1,
  output logic [ADDR_WIDTH-1:0] sram_raddr2,
  output logic [ADDR_WIDTH-1:0] sram_raddr3,
  input  logic [DATA_WIDTH-1:0] sram_rdata0,
  input  logic [DATA_WIDTH-1:0] sram_rdata1,
  input  logic [DATA_WIDTH-1:0] sram_rdata2,
  input  logic [DATA_WIDTH-1:0] sram_rdata3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst0,
  output logic [DATA_WIDTH-1:0] out_inst1,
  output logic [DATA_WIDTH-1:0] out_inst2,
  output logic [DATA_WIDTH-1:0] out_inst3,
  output logic [3:0]            out_mask
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CRW = CW + 1;

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] if_pc_q;
  logic [3:0]            mask;
  logic [3:0]            if_mask_q;
  logic                  inflight_q;
  logic                  issue;
  logic                  pop_req;
  logic                  push;
  logic                  flush;
  logic [CW-1:0]         count;
  logic [CRW-1:0]        credit;
  logic                  empty;
  logic                  full;
  fetch_group_t          din;
  fetch_group_t          head;

  assign base    = {pc_q[ADDR_WIDTH-1:4], 4'b0000};
  assign mask    = group_mask(pc_q[3:2]);
  assign out_valid = ~empty;
  assign pop_req = out_valid & out_ready;

  // Counting this cycle's pop as a free slot lets a depth-2 buffer sustain one group per cycle.
  assign credit = CRW'(count) + CRW'(inflight_q) - CRW'(pop_req);
  assign issue  = fetch_en & ~redirect_valid & ~rst & (credit < CRW'(FIFO_DEPTH));

  assign sram_en0    = issue & mask[0];
  assign sram_en1    = issue & mask[1];
  assign sram_en2    = issue & mask[2];
  assign sram_en3    = issue & mask[3];
  assign sram_raddr0 = base;
  assign sram_raddr1 = base + ADDR_WIDTH'(4);
  assign sram_raddr2 = base + ADDR_WIDTH'(8);
  assign sram_raddr3 = base + ADDR_WIDTH'(12);

  assign flush = rst | redirect_valid;
  assign push  = inflight_q & (state_q == FETCH_RUN) & ~flush;

  // Disabled SRAM lanes still present stale read data, so they are zeroed here.
  always_comb begin
    din         = '0;
    din.pc      = if_pc_q;
    din.mask    = if_mask_q;
    din.inst[0] = if_mask_q[0] ? sram_rdata0 : '0;
    din.inst[1] = if_mask_q[1] ? sram_rdata1 : '0;
    din.inst[2] = if_mask_q[2] ? sram_rdata2 : '0;
    din.inst[3] = if_mask_q[3] ? sram_rdata3 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      if_pc_q    <= '0;
      if_mask_q  <= '0;
    end else begin
      state_q    <= (fetch_en | inflight_q) ? FETCH_RUN : FETCH_IDLE;
      inflight_q <= issue;
      if (issue) begin
        if_pc_q   <= pc_q;
        if_mask_q <= mask;
      end
      if (redirect_valid) begin
        pc_q <= redirect_pc & ~ADDR_WIDTH'(3);
      end else if (issue) begin
        pc_q <= base + ADDR_WIDTH'(GROUP_BYTES);
      end
    end
  end

  fetch_group_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .flush (flush),
    .push  (push),
    .pop   (pop_req),
    .din   (din),
    .count (count),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  assign out_pc    = out_valid ? head.pc      : '0;
  assign out_inst0 = out_valid ? head.inst[0] : '0;
  assign out_inst1 = out_valid ? head.inst[1] : '0;
  assign out_inst2 = out_valid ? head.inst[2] : '0;
  assign out_inst3 = out_valid ? head.inst[3] : '0;
  assign out_mask  = out_valid ? head.mask    : '0;

  always @(posedge clk) begin
    if (!flush) begin
      assert (!(push && full));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// tb_inst_fetch_ctrl: directed fetch scenarios; expected groups are queued at
// issue and compared when decode accepts them.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        sram_en0, sram_en1, sram_en2, sram_en3;
  logic [31:0] sram_raddr0, sram_raddr1, sram_raddr2, sram_raddr3;
  logic [31:0] sram_rdata0 = 32'hDEAD_BEEF;
  logic [31:0] sram_rdata1 = 32'hDEAD_BEEF;
  logic [31:0] sram_rdata2 = 32'hDEAD_BEEF;
  logic [31:0] sram_rdata3 = 32'hDEAD_BEEF;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst0, out_inst1, out_inst2, out_inst3;
  logic [3:0]  out_mask;
  logic [3:0]  en_v;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0]  pc;
    logic [127:0] inst;
    logic [3:0]   mask;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_pc;

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .sram_en0       (sram_en0),
    .sram_en1       (sram_en1),
    .sram_en2       (sram_en2),
    .sram_en3       (sram_en3),
    .sram_raddr0    (sram_raddr0),
    .sram_raddr1    (sram_raddr1),
    .sram_raddr2    (sram_raddr2),
    .sram_raddr3    (sram_raddr3),
    .sram_rdata0    (sram_rdata0),
    .sram_rdata1    (sram_rdata1),
    .sram_rdata2    (sram_rdata2),
    .sram_rdata3    (sram_rdata3),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst0      (out_inst0),
    .out_inst1      (out_inst1),
    .out_inst2      (out_inst2),
    .out_inst3      (out_inst3),
    .out_mask       (out_mask)
  );

  assign en_v = {sram_en3, sram_en2, sram_en1, sram_en0};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Registered SRAM: non-enabled ports keep their previous output.
  always @(posedge clk) begin
    if (sram_en0) sram_rdata0 <= mem_word(sram_raddr0);
    if (sram_en1) sram_rdata1 <= mem_word(sram_raddr1);
    if (sram_en2) sram_rdata2 <= mem_word(sram_raddr2);
    if (sram_en3) sram_rdata3 <= mem_word(sram_raddr3);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0]  m;
    logic [31:0] b;
    exp_t        e;
    exp_t        g;
    if (rst || redirect_valid) begin
      chk(rst ? "en_in_reset" : "en_in_redirect", {28'b0, en_v}, 32'h0);
      sb.delete();
      model_pc = rst ? 32'h8000_0000 : (redirect_pc & ~32'h3);
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_group observed_pc=0x%08h expected=none", out_pc);
        end
        if (sb.size() != 0) begin
          g = sb.pop_front();
          chk("sb_pc", out_pc, g.pc);
          chk("sb_inst0", out_inst0, g.inst[31:0]);
          chk("sb_inst1", out_inst1, g.inst[63:32]);
          chk("sb_inst2", out_inst2, g.inst[95:64]);
          chk("sb_inst3", out_inst3, g.inst[127:96]);
          chk("sb_mask", {28'b0, out_mask}, {28'b0, g.mask});
        end
      end
      m = 4'b1111 << model_pc[3:2];
      b = {model_pc[31:4], 4'b0000};
      if (en_v != 4'b0000) begin
        chk("issue_en", {28'b0, en_v}, {28'b0, m});
        chk("issue_raddr0", sram_raddr0, b);
        chk("issue_raddr1", sram_raddr1, b + 32'd4);
        chk("issue_raddr2", sram_raddr2, b + 32'd8);
        chk("issue_raddr3", sram_raddr3, b + 32'd12);
        e.pc   = model_pc;
        e.mask = m;
        e.inst = '0;
        for (int n = 0; n < 4; n++) begin
          if (m[n]) e.inst[32*n +: 32] = mem_word(b + 32'(4 * n));
        end
        sb.push_back(e);
        model_pc = b + 32'd16;
      end
      if (!out_valid) begin
        chk("empty_out_pc", out_pc, 32'h0);
        chk("empty_out_mask", {28'b0, out_mask}, 32'h0);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    next(); next(); #2;
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_out_mask", {28'b0, out_mask}, 32'h0);
    chk("reset_en", {28'b0, en_v}, 32'h0);

    // Reset release: first group at RESET_PC, visible two cycles later
    next(); rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1; #2;
    chk("t1_c0_en", {28'b0, en_v}, 32'hF);
    chk("t1_c0_raddr0", sram_raddr0, 32'h8000_0000);
    chk("t1_c0_raddr1", sram_raddr1, 32'h8000_0004);
    chk("t1_c0_raddr2", sram_raddr2, 32'h8000_0008);
    chk("t1_c0_raddr3", sram_raddr3, 32'h8000_000C);
    next(); #2;
    chk("t1_c1_valid", {31'b0, out_valid}, 32'h0);
    chk("t1_c1_raddr0", sram_raddr0, 32'h8000_0010);
    next(); #2;
    chk("t1_c2_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_c2_pc", out_pc, 32'h8000_0000);
    chk("t1_c2_mask", {28'b0, out_mask}, 32'hF);
    next(); #2;
    chk("t1_c3_pc", out_pc, 32'h8000_0010);
    repeat (4) begin
      next(); #2;
      chk("t1_stream_valid", {31'b0, out_valid}, 32'h1);
      chk("t1_stream_en", {28'b0, en_v}, 32'hF);
    end

    // Redirect to a mid-group address
    next(); redirect_valid = 1'b1; redirect_pc = 32'h8000_002A; #2;
    chk("t2_redirect_en", {28'b0, en_v}, 32'h0);
    next(); redirect_valid = 1'b0; #2;
    chk("t2_r1_valid", {31'b0, out_valid}, 32'h0);
    chk("t2_r1_en", {28'b0, en_v}, 32'hC);
    chk("t2_r1_raddr0", sram_raddr0, 32'h8000_0020);
    next(); #2;
    chk("t2_r2_valid", {31'b0, out_valid}, 32'h0);
    chk("t2_r2_raddr0", sram_raddr0, 32'h8000_0030);
    next(); #2;
    chk("t2_r3_valid", {31'b0, out_valid}, 32'h1);
    chk("t2_r3_pc", out_pc, 32'h8000_0028);
    chk("t2_r3_mask", {28'b0, out_mask}, 32'hC);
    chk("t2_r3_inst0", out_inst0, 32'h0);
    chk("t2_r3_inst1", out_inst1, 32'h0);
    chk("t2_r3_inst2", out_inst2, mem_word(32'h8000_0028));
    next(); #2;
    chk("t2_r4_pc", out_pc, 32'h8000_0030);

    // Decode stalls for 10 cycles
    next(); out_ready = 1'b0; #2;
    chk("t3_stall_en", {28'b0, en_v}, 32'h0);
    chk("t3_stall_valid", {31'b0, out_valid}, 32'h1);
    repeat (9) begin
      next(); #2;
      chk("t3_stall_en", {28'b0, en_v}, 32'h0);
      chk("t3_stall_valid", {31'b0, out_valid}, 32'h1);
    end
    next(); out_ready = 1'b1; #2;
    chk("t3_release_en", {28'b0, en_v}, 32'hF);
    repeat (3) begin
      next(); #2;
      chk("t3_resume_valid", {31'b0, out_valid}, 32'h1);
      chk("t3_resume_en", {28'b0, en_v}, 32'hF);
    end

    // Redirect with credits exhausted and a response landing this cycle
    next(); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_1000; #2;
    chk("t4_redirect_en", {28'b0, en_v}, 32'h0);
    next(); redirect_valid = 1'b0; out_ready = 1'b1; #2;
    chk("t4_r1_valid", {31'b0, out_valid}, 32'h0);
    chk("t4_r1_en", {28'b0, en_v}, 32'hF);
    chk("t4_r1_raddr0", sram_raddr0, 32'h8000_1000);
    next(); #2;
    chk("t4_r2_valid", {31'b0, out_valid}, 32'h0);
    next(); #2;
    chk("t4_r3_valid", {31'b0, out_valid}, 32'h1);
    chk("t4_r3_pc", out_pc, 32'h8000_1000);

    // Redirect near the top of the address space; next group wraps to 0
    next(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF4; #2;
    chk("t5_redirect_en", {28'b0, en_v}, 32'h0);
    next(); redirect_valid = 1'b0; #2;
    chk("t5_r1_en", {28'b0, en_v}, 32'hE);
    chk("t5_r1_raddr0", sram_raddr0, 32'hFFFF_FFF0);
    chk("t5_r1_raddr3", sram_raddr3, 32'hFFFF_FFFC);
    next(); #2;
    chk("t5_r2_en", {28'b0, en_v}, 32'hF);
    chk("t5_r2_raddr0", sram_raddr0, 32'h0000_0000);
    next(); #2;
    chk("t5_r3_pc", out_pc, 32'hFFFF_FFF4);
    chk("t5_r3_mask", {28'b0, out_mask}, 32'hE);
    chk("t5_r3_inst0", out_inst0, 32'h0);
    next(); #2;
    chk("t5_r4_pc", out_pc, 32'h0000_0000);

    // fetch_en low: drain, pc holds; then reset with a group in flight
    next(); fetch_en = 1'b0; #2;
    chk("t6_f0_en", {28'b0, en_v}, 32'h0);
    next(); #2;
    chk("t6_f1_en", {28'b0, en_v}, 32'h0);
    chk("t6_f1_valid", {31'b0, out_valid}, 32'h1);
    next(); #2;
    chk("t6_f2_valid", {31'b0, out_valid}, 32'h0);
    next(); #2;
    chk("t6_f3_en", {28'b0, en_v}, 32'h0);
    next(); fetch_en = 1'b1; #2;
    chk("t6_pc_held", sram_raddr0, 32'h0000_0030);
    next(); rst = 1'b1; #2;
    chk("t6_rst_en", {28'b0, en_v}, 32'h0);
    next(); rst = 1'b0; #2;
    chk("t6_post_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_post_rst_raddr0", sram_raddr0, 32'h8000_0000);
    chk("t6_post_rst_en", {28'b0, en_v}, 32'hF);
    next(); #2;
    chk("t6_post_rst_valid2", {31'b0, out_valid}, 32'h0);
    next(); #2;
    chk("t6_first_pc", out_pc, 32'h8000_0000);

    next(); fetch_en = 1'b0;
    repeat (4) next();
    #2;
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
